// File: rtl/snn_conv_pe.sv
// snn_conv_pe: spiking-convolution processing element.
// Accumulates spike-gated K x K filter weights into a persistent membrane
// potential, thresholds it once per ifmap window and emits one result packet.
// DATA_W must be >= max(K*FILTER_W, K*K, POT_W+1).
module snn_conv_pe #(
    parameter int unsigned K             = 3,
    parameter int unsigned FILTER_W      = 8,
    parameter int unsigned POT_W         = 16,
    parameter int unsigned ADDR_W        = 4,
    parameter int unsigned DATA_W        = 24,
    parameter int unsigned PKT_W         = 1 + 2 * ADDR_W + DATA_W,
    parameter int unsigned PE_X          = 0,
    parameter int unsigned PE_Y          = 0,
    parameter int unsigned MEM_ADDR      = 13,
    parameter int unsigned RESET_ON_FIRE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_in_valid,
    output logic             pkt_in_ready,
    input  logic [PKT_W-1:0] pkt_in_data,
    output logic             pkt_out_valid,
    input  logic             pkt_out_ready,
    output logic [PKT_W-1:0] pkt_out_data,
    input  logic [POT_W-1:0] threshold,
    input  logic             pot_clear,
    output logic             filter_loaded,
    output logic             err_no_filter
);

    localparam int unsigned TAPS   = K * K;
    localparam int unsigned TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned ROW_W  = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned HALF_W = ADDR_W / 2;

    localparam logic [ADDR_W-1:0] OWN_ADDR = ADDR_W'({HALF_W'(PE_X), HALF_W'(PE_Y)});
    localparam logic [ADDR_W-1:0] DST_ADDR = ADDR_W'(MEM_ADDR);
    localparam logic [POT_W-1:0]  POT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2,
        SEND  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [POT_W-1:0]    pot_q, pot_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [ROW_W-1:0]    tap_r_q, tap_r_d;
    logic [ROW_W-1:0]    tap_c_q, tap_c_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [TAPS-1:0]     spikes_q, spikes_d;
    logic                loaded_q, loaded_d;
    logic                err_q, err_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [PKT_W-1:0]    out_data_q, out_data_d;
    logic                weight_we;

    logic [FILTER_W-1:0] weight_q [K][K];

    logic [DATA_W-1:0]   payload;
    logic                is_ifmap;
    logic [FILTER_W-1:0] w_sel;
    logic [POT_W:0]      sum_c;
    logic [POT_W-1:0]    sat_sum;
    logic                fire_c;
    logic [POT_W-1:0]    post_pot;
    logic                unused_hdr_c;

    assign payload      = pkt_in_data[DATA_W-1:0];
    assign is_ifmap     = pkt_in_data[PKT_W-1];
    assign unused_hdr_c = ^pkt_in_data[PKT_W-2:DATA_W];

    // Tap datapath: saturating add of the selected weight, strict-threshold fire
    assign w_sel    = weight_q[tap_r_q][tap_c_q];
    assign sum_c    = {1'b0, pot_q} + (POT_W + 1)'(w_sel);
    assign sat_sum  = sum_c[POT_W] ? POT_MAX : sum_c[POT_W-1:0];
    assign fire_c   = pot_q > threshold;
    assign post_pot = !fire_c ? pot_q
                    : ((RESET_ON_FIRE != 0) ? '0 : pot_q - threshold);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pkt_in_valid && is_ifmap && loaded_q) state_d = ACCUM;
            ACCUM:   if (tap_q == TAP_W'(TAPS - 1)) state_d = FIRE;
            FIRE:    state_d = SEND;
            SEND:    if (pkt_out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values for each state
    always_comb begin
        pot_d       = pot_q;
        tap_d       = tap_q;
        tap_r_d     = tap_r_q;
        tap_c_d     = tap_c_q;
        row_d       = row_q;
        spikes_d    = spikes_q;
        loaded_d    = loaded_q;
        err_d       = 1'b0;
        out_data_d  = out_data_q;
        weight_we   = 1'b0;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == SEND);
        unique case (state_q)
            IDLE: begin
                if (pot_clear) begin
                    pot_d = '0;
                end
                if (pkt_in_valid) begin
                    if (!is_ifmap) begin
                        // Filter row: write current row, wrap after the last one
                        weight_we = 1'b1;
                        if (row_q == ROW_W'(K - 1)) begin
                            row_d    = '0;
                            loaded_d = 1'b1;
                        end else begin
                            row_d    = row_q + ROW_W'(1);
                            loaded_d = 1'b0;
                        end
                    end else if (!loaded_q) begin
                        err_d = 1'b1;
                    end else begin
                        spikes_d = payload[TAPS-1:0];
                        tap_d    = '0;
                        tap_r_d  = '0;
                        tap_c_d  = '0;
                    end
                end
            end
            ACCUM: begin
                if (spikes_q[0]) begin
                    pot_d = sat_sum;
                end
                spikes_d = spikes_q >> 1;
                tap_d    = tap_q + TAP_W'(1);
                if (tap_c_q == ROW_W'(K - 1)) begin
                    tap_c_d = '0;
                    tap_r_d = tap_r_q + ROW_W'(1);
                end else begin
                    tap_c_d = tap_c_q + ROW_W'(1);
                end
            end
            FIRE: begin
                pot_d      = post_pot;
                out_data_d = {1'b0, DST_ADDR, OWN_ADDR, DATA_W'({post_pot, fire_c})};
            end
            SEND: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            pot_q       <= '0;
            tap_q       <= '0;
            tap_r_q     <= '0;
            tap_c_q     <= '0;
            row_q       <= '0;
            spikes_q    <= '0;
            loaded_q    <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            pot_q       <= pot_d;
            tap_q       <= tap_d;
            tap_r_q     <= tap_r_d;
            tap_c_q     <= tap_c_d;
            row_q       <= row_d;
            spikes_q    <= spikes_d;
            loaded_q    <= loaded_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Weight store keeps its contents across reset
    always_ff @(posedge clk) begin
        if (weight_we) begin
            for (int c = 0; c < int'(K); c++) begin
                weight_q[row_q][c] <= payload[c*FILTER_W +: FILTER_W];
            end
        end
    end

    assign pkt_in_ready  = in_ready_q;
    assign pkt_out_valid = out_valid_q;
    assign pkt_out_data  = out_data_q;
    assign filter_loaded = loaded_q;
    assign err_no_filter = err_q;

endmodule
